crab_mem_ctrl: RTL and testbench

//  Single-port word memory that services the crabcore memory request bus.

---
 rtl/crab_mem_ctrl.sv | 108 ++++++++++
 tb/tb_crab_mem_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/crab_mem_ctrl.sv
// Single-port word memory for the crabcore request bus, with a boot-loader write port.
// Latency: accept edge k -> one-cycle mem_ready pulse after edge k+1+WAIT_CYCLES.
// Backpressure: new requests are only accepted in IDLE (mem_busy=0); loads only in idle gaps.
module crab_mem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_addr_valid,
    input  logic [31:0] mem_addr,
    input  logic        mem_data_valid,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic [31:0] mem_input,
    output logic        mem_err,
    output logic        mem_busy,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] req_count
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q, wdata_q;
    logic        write_q;
    logic [31:0] ram [DEPTH];

    logic          accept, resp_fire, ram_we, load_we, req_err;
    logic [IW-1:0] req_idx, load_idx;

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
    endfunction

    assign req_err  = bad_addr(addr_q);
    assign req_idx  = addr_q[IW+1:2];
    assign load_idx = load_addr[IW+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept)
                wait_cnt <= WAIT_INIT;
            else if (state == S_WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (mem_addr_valid) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (wait_cnt == 4'd0) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reset gates both write paths so an abandoned transaction never lands in RAM.
    always_comb begin
        mem_busy  = (state != S_IDLE);
        accept    = (state == S_IDLE) && mem_addr_valid;
        resp_fire = (state == S_RESP);
        ram_we    = resp_fire && write_q && !req_err && !reset;
        load_we   = (state == S_IDLE) && !mem_addr_valid && load_en
                    && !bad_addr(load_addr) && !reset;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_data;
            write_q <= mem_data_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_input <= 32'd0;
            mem_err   <= 1'b0;
            req_count <= 32'd0;
        end else begin
            mem_ready <= resp_fire;
            if (resp_fire) begin
                mem_err   <= req_err;
                mem_input <= req_err ? 32'd0 : (write_q ? wdata_q : ram[req_idx]);
                req_count <= req_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[req_idx] <= wdata_q;
        else if (load_we)
            ram[load_idx] <= load_data;
    end
endmodule

// File: tb/tb_crab_mem_ctrl.sv
// Directed bench for crab_mem_ctrl: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_crab_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        av, dv, ld_en;
    logic [31:0] addr, wd, ld_addr, ld_data;
    logic        rdy, err, busy;
    logic [31:0] rin, rc;

    logic        z_av, z_dv, z_ld_en;
    logic [31:0] z_addr, z_wd, z_ld_addr, z_ld_data;
    logic        z_rdy, z_err, z_busy;
    logic [31:0] z_rin, z_rc;

    int n_tot = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    crab_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .mem_addr_valid(av), .mem_addr(addr), .mem_data_valid(dv), .mem_data(wd),
        .mem_ready(rdy), .mem_input(rin), .mem_err(err), .mem_busy(busy),
        .load_en(ld_en), .load_addr(ld_addr), .load_data(ld_data), .req_count(rc)
    );

    crab_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .mem_addr_valid(z_av), .mem_addr(z_addr), .mem_data_valid(z_dv), .mem_data(z_wd),
        .mem_ready(z_rdy), .mem_input(z_rin), .mem_err(z_err), .mem_busy(z_busy),
        .load_en(z_ld_en), .load_addr(z_ld_addr), .load_data(z_ld_data), .req_count(z_rc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    // Issue one request, wait for its pulse, check latency/data/err/count and pulse width.
    task automatic req(input string tag, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        int lat;
        lat = 0;
        av = 1'b1; dv = we; addr = a; wd = d;
        step();
        av = 1'b0; dv = 1'b0; addr = '0; wd = '0; ld_en = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (rdy) begin
                lat = i;
                break;
            end
        end
        exp_cnt++;
        chk({tag, " latency"}, 32'(lat), 32'd3);
        chk({tag, " data"}, rin, exp_d);
        chk({tag, " err"}, {31'd0, err}, {31'd0, exp_e});
        chk({tag, " count"}, rc, 32'(exp_cnt));
        step();
        chk({tag, " pulse end"}, {31'd0, rdy}, 32'd0);
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        av = 0; dv = 0; addr = 0; wd = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
        z_av = 0; z_dv = 0; z_addr = 0; z_wd = 0; z_ld_en = 0; z_ld_addr = 0; z_ld_data = 0;
        step();
        step();
        chk("reset ready", {31'd0, rdy}, 32'd0);
        chk("reset input", rin, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset count", rc, 32'd0);
        reset = 1'b0;
        step();

        load(32'h0, 32'h0050_0093);
        load(32'h4, 32'h1234_5678);
        load(32'h20, 32'h0);
        req("rd0", 1'b0, 32'h0, 32'h0, 32'h0050_0093, 1'b0);
        req("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        req("rd10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        req("rd_mis", 1'b0, 32'h2, 32'h0, 32'h0, 1'b1);
        req("rd_oor", 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
        req("wr_mis", 1'b1, 32'h12, 32'h1111_1111, 32'h0, 1'b1);
        req("wr_oor", 1'b1, 32'h1010, 32'h2222_2222, 32'h0, 1'b1);
        req("rd10 again", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // mem_addr_valid held high for 10 edges: accepts at edges 0, 4, 8.
        pulses = 0;
        av = 1'b1; addr = 32'h4;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rdy) pulses++;
        end
        av = 1'b0; addr = '0;
        chk("hold pulses", 32'(pulses), 32'd2);
        chk("hold busy", {31'd0, busy}, 32'd1);
        chk("hold count2", rc, 32'(exp_cnt + 2));
        for (int i = 0; i < 10; i++) begin
            step();
            if (rdy) break;
        end
        exp_cnt += 3;
        chk("hold third ready", {31'd0, rdy}, 32'd1);
        chk("hold data", rin, 32'h1234_5678);
        chk("hold count3", rc, 32'(exp_cnt));

        // Reset while a write sits in WAIT: abandoned, no write, outputs cleared.
        av = 1'b1; dv = 1'b1; addr = 32'h0; wd = 32'hBAD0_BAD0;
        step();
        av = 1'b0; dv = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_cnt = 0;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst input", rin, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst count", rc, 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rdy) pulses++;
        end
        chk("rst no pulse", 32'(pulses), 32'd0);
        req("rd0 after rst", 1'b0, 32'h0, 32'h0, 32'h0050_0093, 1'b0);

        // Load coinciding with a request, misaligned/out-of-range loads, load while busy.
        ld_en = 1'b1; ld_addr = 32'h20; ld_data = 32'hCAFE_F00D;
        req("coincide", 1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0);
        load(32'h22, 32'h7777_7777);
        load(32'h1020, 32'h8888_8888);
        av = 1'b1; addr = 32'h0;
        step();
        av = 1'b0;
        ld_en = 1'b1; ld_addr = 32'h20; ld_data = 32'h5555_5555;
        step();
        step();
        ld_en = 1'b0;
        step();
        exp_cnt++;
        chk("busy load ready", {31'd0, rdy}, 32'd1);
        step();
        req("rd20", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        // Zero-wait-state instance.
        z_ld_en = 1'b1; z_ld_addr = 32'h8; z_ld_data = 32'hA5A5_A5A5;
        step();
        z_ld_en = 1'b0;
        z_av = 1'b1; z_addr = 32'h8;
        step();
        z_av = 1'b0;
        chk("w0 busy", {31'd0, z_busy}, 32'd1);
        step();
        chk("w0 ready", {31'd0, z_rdy}, 32'd1);
        chk("w0 data", z_rin, 32'hA5A5_A5A5);
        chk("w0 count", z_rc, 32'd1);
        step();
        chk("w0 pulse end", {31'd0, z_rdy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
